// File: rtl/psum_accum_stage.sv
// ---------------------------------------------------------------------------
// psum_accum_stage
//
// Purpose:
//   Accumulates n_acc consecutive signed partial sums from the MAC. One partial
//   sum arrives per K-tile. The stage saturates the running sum to bw_acc bits
//   and can optionally apply ReLU. Each finished result is presented to the
//   write-back buffer on a valid/ready output.
//
// Handshake (both sides): a beat transfers on a rising clk edge where
//   valid & ready are both high. A producer holds its payload stable while
//   valid is high and ready is low. in_ready never depends on in_valid.
//
// Parameters:
//   bw_psum  width of the signed partial sum (must be <= bw_acc)
//   bw_acc   width of the signed accumulated / saturated result
//   n_acc    partial sums per result (>= 2)
//   relu_en  1: negative final results are forced to 0
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   in_valid   in_psum is valid this cycle
//   in_ready   stage can accept in_psum this cycle
//   in_psum    signed partial sum from the MAC
//   out_valid  out_data/out_sat hold a completed result
//   out_ready  downstream accepts the result this cycle
//   out_data   signed accumulated result (post-saturation, post-ReLU)
//   out_sat    result saturated at least once during its accumulation
// ---------------------------------------------------------------------------
module psum_accum_stage #(
    parameter int bw_psum = 20,
    parameter int bw_acc  = 24,
    parameter int n_acc   = 4,
    parameter int relu_en = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [bw_psum-1:0] in_psum,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [bw_acc-1:0]  out_data,
    output logic                      out_sat
);

    localparam int cw = (n_acc > 1) ? $clog2(n_acc) : 1;
    localparam logic [cw-1:0] last_cnt = cw'(n_acc - 1);
    localparam logic signed [bw_acc-1:0] acc_max = {1'b0, {(bw_acc-1){1'b1}}};
    localparam logic signed [bw_acc-1:0] acc_min = {1'b1, {(bw_acc-1){1'b0}}};

    // Accumulation phase, decoded from cnt; kept as a named signal so
    // checkers can bind to it directly.
    typedef enum logic [1:0] {
        PH_FIRST = 2'd0,
        PH_MID   = 2'd1,
        PH_LAST  = 2'd2
    } phase_t;

    logic [cw-1:0]             cnt;
    logic signed [bw_acc-1:0]  acc;
    logic                      sat_acc;

    phase_t                    phase;
    logic                      is_first;
    logic                      is_last;
    logic                      in_fire;
    logic                      out_fire;
    logic signed [bw_acc-1:0]  base;
    logic signed [bw_acc:0]    sum;
    logic                      clamped;
    logic signed [bw_acc-1:0]  sum_sat;
    logic signed [bw_acc-1:0]  result;

    always_comb begin
        is_first = (cnt == '0);
        is_last  = (cnt == last_cnt);
        if (is_last)       phase = PH_LAST;
        else if (is_first) phase = PH_FIRST;
        else               phase = PH_MID;

        // Only a LAST beat needs the output slot, so only it can stall.
        in_ready = !(out_valid && !out_ready && is_last);
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;

        // One extra bit of headroom: adding a bw_psum value to a bw_acc value
        // can overflow by at most one bit, so a sign mismatch between the
        // top two bits is exactly the overflow condition.
        base    = is_first ? '0 : acc;
        sum     = {base[bw_acc-1], base}
                + {{(bw_acc+1-bw_psum){in_psum[bw_psum-1]}}, in_psum};
        clamped = (sum[bw_acc] != sum[bw_acc-1]);
        if (clamped) sum_sat = sum[bw_acc] ? acc_min : acc_max;
        else         sum_sat = sum[bw_acc-1:0];

        // ReLU acts on the saturated value; it does not affect out_sat.
        if ((relu_en != 0) && sum_sat[bw_acc-1]) result = '0;
        else                                     result = sum_sat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            sat_acc   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (out_fire) begin
                out_valid <= 1'b0;
            end
            if (in_fire) begin
                if (is_last) begin
                    // Overrides the clear above when a result leaves and a
                    // new one lands on the same edge.
                    out_data  <= result;
                    out_sat   <= sat_acc | clamped;
                    out_valid <= 1'b1;
                    cnt       <= '0;
                end else begin
                    acc     <= sum_sat;
                    sat_acc <= (is_first ? 1'b0 : sat_acc) | clamped;
                    cnt     <= cnt + cw'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_psum_accum_stage.sv
// ---------------------------------------------------------------------------
// tb_psum_accum_stage
//
// Directed bench for psum_accum_stage. Three instances are used:
//   d_*  default parameters
//   s_*  bw_acc=20 for saturation boundaries
//   r_*  relu_en=1
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_psum_accum_stage;

    logic clk;
    logic rst_n;

    // default instance
    logic               d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_sat;
    logic signed [19:0] d_in_psum;
    logic signed [23:0] d_out_data;
    // saturation instance (bw_acc = 20)
    logic               s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_sat;
    logic signed [19:0] s_in_psum;
    logic signed [19:0] s_out_data;
    // relu instance
    logic               r_in_valid, r_in_ready, r_out_valid, r_out_ready, r_out_sat;
    logic signed [19:0] r_in_psum;
    logic signed [23:0] r_out_data;

    int n_cmp = 0;
    int n_err = 0;

    psum_accum_stage u_def (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_psum(d_in_psum),
        .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_data(d_out_data), .out_sat(d_out_sat)
    );

    psum_accum_stage #(.bw_psum(20), .bw_acc(20), .n_acc(4), .relu_en(0)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_psum(s_in_psum),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_sat(s_out_sat)
    );

    psum_accum_stage #(.bw_psum(20), .bw_acc(24), .n_acc(4), .relu_en(1)) u_relu (
        .clk(clk), .rst_n(rst_n),
        .in_valid(r_in_valid), .in_ready(r_in_ready), .in_psum(r_in_psum),
        .out_valid(r_out_valid), .out_ready(r_out_ready),
        .out_data(r_out_data), .out_sat(r_out_sat)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // sel: 0 = default, 1 = saturation, 2 = relu instance
    task automatic drive(input int sel, input logic valid, input int val);
        case (sel)
            0: begin d_in_valid = valid; d_in_psum = 20'(val); end
            1: begin s_in_valid = valid; s_in_psum = 20'(val); end
            default: begin r_in_valid = valid; r_in_psum = 20'(val); end
        endcase
    endtask

    // Four back-to-back beats; returns at the falling edge after the 4th
    // rising edge, with in_valid dropped.
    task automatic feed4(input int sel, input int a, input int b, input int c, input int e);
        int v[4];
        v = '{a, b, c, e};
        for (int i = 0; i < 4; i++) begin
            drive(sel, 1'b1, v[i]);
            @(negedge clk);
        end
        drive(sel, 1'b0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 0); drive(1, 1'b0, 0); drive(2, 1'b0, 0);
        d_out_ready = 1'b1; s_out_ready = 1'b1; r_out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_out_valid", 32'(d_out_valid), 0);
        check("rst_out_data",  32'(d_out_data), 0);
        check("rst_out_sat",   32'(d_out_sat), 0);
        check("rst_in_ready",  32'(d_in_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: 100 - 30 + 7 - 2 = 75
        feed4(0, 100, -30, 7, -2);
        check("t1_out_valid", 32'(d_out_valid), 1);
        check("t1_out_data",  32'(d_out_data), 75);
        check("t1_out_sat",   32'(d_out_sat), 0);
        @(negedge clk);
        check("t1_pulse_end", 32'(d_out_valid), 0);

        // 2: eight +1 beats -> results of 4 at falling edges 4 and 8
        for (int i = 0; i <= 8; i++) begin
            check("t2_in_ready", 32'(d_in_ready), 1);
            check("t2_out_valid", 32'(d_out_valid), ((i == 4) || (i == 8)) ? 1 : 0);
            if ((i == 4) || (i == 8)) check("t2_out_data", 32'(d_out_data), 4);
            drive(0, (i < 8), 1);
            @(negedge clk);
        end
        check("t2_idle", 32'(d_out_valid), 0);

        // 3: back-pressure with a pending result
        feed4(0, 1, 1, 1, 1);
        check("t3_first_valid", 32'(d_out_valid), 1);
        check("t3_first_data",  32'(d_out_data), 4);
        d_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_mid_ready", 32'(d_in_ready), 1);
            drive(0, 1'b1, 2);
            @(negedge clk);
        end
        check("t3_stall_ready", 32'(d_in_ready), 0);
        check("t3_hold_valid",  32'(d_out_valid), 1);
        check("t3_hold_data",   32'(d_out_data), 4);
        @(negedge clk);
        check("t3_stall_ready2", 32'(d_in_ready), 0);
        check("t3_hold_data2",   32'(d_out_data), 4);
        d_out_ready = 1'b1;
        #1;
        check("t3_release_ready", 32'(d_in_ready), 1);
        @(negedge clk);
        drive(0, 1'b0, 0);
        check("t3_next_valid", 32'(d_out_valid), 1);
        check("t3_next_data",  32'(d_out_data), 8);
        @(negedge clk);
        check("t3_drained", 32'(d_out_valid), 0);

        // 4: saturation at bw_acc = 20
        feed4(1, 524287, 524287, -1, 0);
        check("t4_sat_valid", 32'(s_out_valid), 1);
        check("t4_sat_data",  32'(s_out_data), 524286);
        check("t4_sat_flag",  32'(s_out_sat), 1);
        feed4(1, 1, 1, 1, 1);
        check("t4_clean_data", 32'(s_out_data), 4);
        check("t4_clean_flag", 32'(s_out_sat), 0);
        feed4(1, -524288, -524288, 0, 0);
        check("t4_neg_data", 32'(s_out_data), -524288);
        check("t4_neg_flag", 32'(s_out_sat), 1);

        // 5: relu
        feed4(2, -50, 10, 0, 0);
        check("t5_relu_valid", 32'(r_out_valid), 1);
        check("t5_relu_data",  32'(r_out_data), 0);
        check("t5_relu_flag",  32'(r_out_sat), 0);
        feed4(2, 5, 5, 5, 5);
        check("t5_pos_data", 32'(r_out_data), 20);

        // 6: async reset with a held result and a partial accumulation
        d_out_ready = 1'b0;
        feed4(0, 3, 3, 3, 3);
        check("t6_held_data", 32'(d_out_data), 12);
        drive(0, 1'b1, 9);
        @(negedge clk);
        drive(0, 1'b1, 9);
        @(negedge clk);
        drive(0, 1'b0, 0);
        check("t6_pre_valid", 32'(d_out_valid), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(d_out_valid), 0);
        check("t6_rst_data",  32'(d_out_data), 0);
        check("t6_rst_sat",   32'(d_out_sat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        d_out_ready = 1'b1;
        feed4(0, 1, 2, 3, 4);
        check("t6_after_valid", 32'(d_out_valid), 1);
        check("t6_after_data",  32'(d_out_data), 10);
        check("t6_after_sat",   32'(d_out_sat), 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
